// File: rtl/pri_arb_enc_n_if.sv
// Request/index handshake bundle for pri_arb_enc_n: requests and ready in, selected index out.
// The master side is the requester/consumer; the slave side is the arbiter.
interface pri_arb_enc_n_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         busy;

  modport master (
    output en, req, out_ready,
    input  out_valid, out_idx, busy
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, out_idx, busy
  );
endinterface

// File: rtl/pri_arb_enc_n.sv
// Registered N-input arbiter, fixed priority (highest index) or round-robin; req->out_valid in 1 cycle.
// out_idx is held while out_ready is low; a new winner loads on the same edge an index is accepted.
module pri_arb_enc_n #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter bit RR_MODE = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pri_arb_enc_n_if.slave io_arb
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_ptr;

  logic         w_valid;
  logic         w_accept;
  logic         w_load;
  logic [W-1:0] w_scan_ptr;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic         w_lo_hit;
  logic [W-1:0] w_win;

  assign w_valid  = (r_state == FULL);
  assign w_accept = w_valid && io_arb.out_ready;
  assign w_load   = io_arb.en && (|io_arb.req) && (!w_valid || io_arb.out_ready);

  // The index leaving this cycle is the pointer the next scan rotates from.
  assign w_scan_ptr = w_accept ? r_idx : r_ptr;

  // Downward scan from ptr-1 with wrap = highest set bit below ptr, else highest set bit overall.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    w_lo_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (io_arb.req[i]) begin
        w_hi_idx = W'(i);
        if (W'(i) < w_scan_ptr) begin
          w_lo_idx = W'(i);
          w_lo_hit = 1'b1;
        end
      end
    end
  end

  assign w_win = (RR_MODE && w_lo_hit) ? w_lo_idx : w_hi_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_load) begin
            r_idx   <= w_win;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (io_arb.out_ready) begin
            r_ptr <= r_idx;
            if (w_load) begin
              r_idx <= w_win;
            end else begin
              r_state <= EMPTY;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign io_arb.out_valid = w_valid;
  assign io_arb.out_idx   = r_idx;
  assign io_arb.busy      = w_valid && !io_arb.out_ready;

endmodule

// File: tb/tb_pri_arb_enc_n.sv
// Bench for pri_arb_enc_n: fixed N=8, round-robin N=8 and round-robin N=5 instances on shared stimulus.
module tb_pri_arb_enc_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       rdy;

  int nvec = 0;
  int mism = 0;

  pri_arb_enc_n_if #(.N(8), .W(3)) if_fix ();
  pri_arb_enc_n_if #(.N(8), .W(3)) if_rr ();
  pri_arb_enc_n_if #(.N(5), .W(3)) if_rr5 ();

  assign if_fix.en        = en;
  assign if_fix.req       = req;
  assign if_fix.out_ready = rdy;
  assign if_rr.en         = en;
  assign if_rr.req        = req;
  assign if_rr.out_ready  = rdy;
  assign if_rr5.en        = en;
  assign if_rr5.req       = req[4:0];
  assign if_rr5.out_ready = rdy;

  pri_arb_enc_n #(.N(8), .W(3), .RR_MODE(1'b0)) u_fix (.i_clk(clk), .i_rst_n(rst_n), .io_arb(if_fix));
  pri_arb_enc_n #(.N(8), .W(3), .RR_MODE(1'b1)) u_rr  (.i_clk(clk), .i_rst_n(rst_n), .io_arb(if_rr));
  pri_arb_enc_n #(.N(5), .W(3), .RR_MODE(1'b1)) u_rr5 (.i_clk(clk), .i_rst_n(rst_n), .io_arb(if_rr5));

  initial forever #5 clk = ~clk;

  logic       dv [3];
  logic [2:0] di [3];
  logic       db [3];
  assign dv[0] = if_fix.out_valid;
  assign di[0] = if_fix.out_idx;
  assign db[0] = if_fix.busy;
  assign dv[1] = if_rr.out_valid;
  assign di[1] = if_rr.out_idx;
  assign db[1] = if_rr.busy;
  assign dv[2] = if_rr5.out_valid;
  assign di[2] = if_rr5.out_idx;
  assign db[2] = if_rr5.busy;

  // Reference model: state of each instance, winner picked by walking the priority order.
  int ns  [3] = '{8, 8, 5};
  int rrm [3] = '{0, 1, 1};
  bit m_vld [3];
  int m_idx [3];
  int m_ptr [3];

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 1'b0;
      m_idx[k] = 0;
      m_ptr[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int         n;
    logic [7:0] r;
    bit         acc;
    bit         ld;
    bit         found;
    int         p;
    int         win;
    int         c;
    n     = ns[k];
    r     = req & 8'((1 << n) - 1);
    acc   = m_vld[k] && rdy;
    ld    = en && (r != 8'h00) && (!m_vld[k] || rdy);
    p     = acc ? m_idx[k] : m_ptr[k];
    win   = 0;
    found = 1'b0;
    if (rrm[k] == 0) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && r[i]) begin
          win   = i;
          found = 1'b1;
        end
      end
    end else begin
      for (int s = 1; s <= n; s++) begin
        c = (p + n - s) % n;
        if (!found && r[c]) begin
          win   = c;
          found = 1'b1;
        end
      end
    end
    if (acc) m_ptr[k] = m_idx[k];
    if (ld) begin
      m_idx[k] = win;
      m_vld[k] = 1'b1;
    end else if (acc) begin
      m_vld[k] = 1'b0;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_valid[%0d]", k), int'(dv[k]), int'(m_vld[k]));
      if (m_vld[k]) chk($sformatf("model_idx[%0d]", k), int'(di[k]), m_idx[k]);
      chk($sformatf("model_busy[%0d]", k), int'(db[k]), int'(m_vld[k] && !rdy));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    en    = 1'b0;
    req   = 8'h00;
    rdy   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_valid[%0d]", k), int'(dv[k]), 0);
      chk($sformatf("reset_idx[%0d]", k), int'(di[k]), 0);
      chk($sformatf("reset_busy[%0d]", k), int'(db[k]), 0);
    end
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic       vld;
    logic [2:0] fix;
    logic [2:0] rr;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic e, logic [7:0] r, logic y, logic v, logic [2:0] f, logic [2:0] rr, logic b);
    vec_t t;
    t.en = e; t.req = r; t.rdy = y; t.vld = v; t.fix = f; t.rr = rr; t.busy = b;
    tbl.push_back(t);
  endtask

  int exp3 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int exp4 [4] = '{5, 0, 5, 0};

  initial begin
    en    = 1'b0;
    req   = 8'h00;
    rdy   = 1'b0;
    rst_n = 1'b0;

    // Expected outputs after the edge on which each row's inputs are sampled.
    add(1, 8'h80, 1, 1, 7, 7, 0);
    add(1, 8'h14, 1, 1, 4, 4, 0);
    add(1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 8'h0C, 0, 1, 3, 3, 1);
    add(1, 8'h0C, 0, 1, 3, 3, 1);
    add(1, 8'h0C, 0, 1, 3, 3, 1);
    add(1, 8'h40, 0, 1, 3, 3, 1);
    add(1, 8'h40, 0, 1, 3, 3, 1);
    add(1, 8'h40, 1, 1, 6, 6, 0);
    add(1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 8'hFF, 1, 1, 7, 5, 0);
    add(1, 8'hFF, 1, 1, 7, 4, 0);
    add(0, 8'hFF, 1, 0, 0, 0, 0);
    add(0, 8'hFF, 1, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 1, 7, 3, 1);
    add(0, 8'hFF, 0, 1, 7, 3, 1);
    add(0, 8'hFF, 1, 0, 0, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      en  = tbl[i].en;
      req = tbl[i].req;
      rdy = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_fix_valid", i), int'(dv[0]), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_rr_valid", i), int'(dv[1]), int'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_fix_idx", i), int'(di[0]), int'(tbl[i].fix));
        chk($sformatf("tbl%0d_rr_idx", i), int'(di[1]), int'(tbl[i].rr));
      end
      chk($sformatf("tbl%0d_busy", i), int'(db[0]), int'(tbl[i].busy));
    end

    // Round-robin sweep over all-ones, wrapping back to 7.
    do_reset();
    en = 1'b1; req = 8'hFF; rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_sweep%0d", i), int'(di[1]), exp3[i]);
      chk($sformatf("fix_sweep%0d", i), int'(di[0]), 7);
    end

    // Two held requesters: RR alternates, fixed keeps the higher one.
    do_reset();
    en = 1'b1; req = 8'h21; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_pair%0d", i), int'(di[1]), exp4[i]);
      chk($sformatf("fix_pair%0d", i), int'(di[0]), 5);
    end

    // Asynchronous reset while stalled, then RR restarts from the top.
    do_reset();
    en = 1'b1; req = 8'h0C; rdy = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_valid[%0d]", k), int'(dv[k]), 0);
      chk($sformatf("arst_idx[%0d]", k), int'(di[k]), 0);
      chk($sformatf("arst_busy[%0d]", k), int'(db[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF; rdy = 1'b1;
    step();
    chk("arst_rr_restart", int'(di[1]), 7);
    chk("arst_rr5_restart", int'(di[2]), 4);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       req = 8'($urandom);
        1:       req = 8'(1 << $urandom_range(0, 7));
        2:       req = 8'h00;
        default: req = 8'($urandom) & 8'($urandom);
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, mism);
    $finish;
  end

endmodule
